// File: rtl/ddsm_ctrl_pkg.sv
// Shared types and helpers for the delta-sigma ramp controller.
package ddsm_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 9;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    SETTLE
  } ctrl_state_t;

  // Counter width for a modulus of n, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddsm_tick_div.sv
// Step-rate divider: tick is high on the cycle the counter sits at DIV-1 while enabled.
module ddsm_tick_div
  import ddsm_ctrl_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ddsm_ramp_ctrl.sv
// Ramps the HK-MASH fractional input toward a requested target, then waits out the modulator latency.
// Optional macro DDSM_RAMP_LSB_DITHER_EN forces the x_o LSB high.
module ddsm_ramp_ctrl
  import ddsm_ctrl_pkg::*;
#(
  parameter int             WIDTH      = DEFAULT_WIDTH,
  parameter int             DIV        = 4,
  parameter int             SETTLE_CYC = 3,
  parameter logic [WIDTH-1:0] RESET_WORD = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [WIDTH-1:0] cfg_word_i,
  input  logic [WIDTH-1:0] cfg_step_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] x_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             settled_o
);

  localparam int SW = cnt_width(SETTLE_CYC);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  ctrl_state_t      state;
  logic [WIDTH-1:0] x_int;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] step;
  logic [SW-1:0]    settle_cnt;
  logic             accept;
  logic             tick;
  logic             up;
  logic             last_step;
  logic [WIDTH:0]   diff;

  assign accept = cfg_valid_i && cfg_ready_o;

  ddsm_tick_div #(.DIV(DIV)) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (state == RAMP),
    .tick (tick)
  );

  // The extra bit keeps the distance exact; a step no smaller than it lands on target.
  always_comb begin
    up        = (target >= x_int);
    diff      = up ? ({1'b0, target} - {1'b0, x_int}) : ({1'b0, x_int} - {1'b0, target});
    last_step = (step == '0) || (diff <= {1'b0, step});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x_int       <= RESET_WORD;
      target      <= '0;
      step        <= '0;
      settle_cnt  <= '0;
      cfg_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      settled_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            target      <= cfg_word_i;
            step        <= cfg_step_i;
            settled_o   <= 1'b0;
            cfg_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state       <= RAMP;
          end
        end
        RAMP: begin
          if (abort_i) begin
            cfg_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end else if (tick) begin
            if (last_step) begin
              x_int      <= target;
              settle_cnt <= '0;
              state      <= SETTLE;
            end else begin
              x_int <= up ? (x_int + step) : (x_int - step);
            end
          end
        end
        SETTLE: begin
          if (abort_i) begin
            cfg_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end else if (settle_cnt == SETTLE_LAST) begin
            done_o      <= 1'b1;
            settled_o   <= 1'b1;
            cfg_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            settle_cnt  <= '0;
            state       <= IDLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Dithering only touches the output; ramp arithmetic stays on x_int.
`ifdef DDSM_RAMP_LSB_DITHER_EN
  assign x_o = x_int | WIDTH'(1);
`else
  assign x_o = x_int;
`endif

endmodule

// File: tb/tb_ddsm_ramp_ctrl.sv
// Scoreboard bench for ddsm_ramp_ctrl: directed requests push expected x_o updates and done pulses.
module tb_ddsm_ramp_ctrl;

  localparam int WIDTH = 9;

  logic             clk;
  logic             rst;
  logic             cfg_valid_i;
  logic             cfg_ready_o;
  logic [WIDTH-1:0] cfg_word_i;
  logic [WIDTH-1:0] cfg_step_i;
  logic             abort_i;
  logic [WIDTH-1:0] x_o;
  logic             busy_o;
  logic             done_o;
  logic             settled_o;

  typedef struct {
    int value;
    int cyc;
  } exp_t;

  exp_t xq[$];
  exp_t dq[$];
  int   cyc;
  int   checks;
  int   errors;
  int   prev_x;

  ddsm_ramp_ctrl #(
    .WIDTH      (WIDTH),
    .DIV        (4),
    .SETTLE_CYC (3),
    .RESET_WORD ('0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_word_i  (cfg_word_i),
    .cfg_step_i  (cfg_step_i),
    .abort_i     (abort_i),
    .x_o         (x_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .settled_o   (settled_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed word: the dithered build always shows an odd value
  function automatic int dx(input int v);
`ifdef DDSM_RAMP_LSB_DITHER_EN
    return v | 1;
`else
    return v;
`endif
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushX(input int value, input int edge_no);
    xq.push_back('{value: value, cyc: edge_no});
  endtask

  task automatic pushDone(input int value, input int edge_no);
    dq.push_back('{value: value, cyc: edge_no});
  endtask

  // Holds cfg_valid_i until an edge sees cfg_ready_o high; returns that edge number
  task automatic applyStimulus(input int word, input int stp, output int acc_edge);
    int guard;
    logic r;
    int e;
    guard    = 0;
    acc_edge = -1;
    cfg_word_i = WIDTH'(word);
    cfg_step_i = WIDTH'(stp);
    while (acc_edge < 0 && guard < 200) begin
      @(negedge clk);
      r = cfg_ready_o;
      e = cyc + 1;
      cfg_valid_i = 1'b1;
      @(posedge clk);
      if (r) acc_edge = e;
      guard++;
    end
    #1 cfg_valid_i = 1'b0;
    if (acc_edge < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept, expected accept of word %0d", word);
    end
  endtask

  task automatic waitDrain(input int bound);
    int g;
    g = 0;
    while ((xq.size() != 0 || dq.size() != 0) && g < bound) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    checkOutput("pending_events", xq.size() + dq.size(), 0);
    xq.delete();
    dq.delete();
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_x", int'(x_o), dx(0));
    checkOutput("reset_ready", int'(cfg_ready_o), 1);
    checkOutput("reset_busy", int'(busy_o), 0);
    checkOutput("reset_settled", int'(settled_o), 0);
    checkOutput("reset_done", int'(done_o), 0);
  endtask

  task automatic monitorStep();
    exp_t e;
    if (rst) begin
      prev_x = int'(x_o);
    end else begin
      if (int'(x_o) != prev_x) begin
        if (xq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL x_change: got x_o=%0d, expected no change from %0d", x_o, prev_x);
        end else begin
          e = xq.pop_front();
          checkOutput("x_value", int'(x_o), dx(e.value));
          checkOutput("x_cycle", cyc, e.cyc);
        end
      end
      prev_x = int'(x_o);
      if (done_o) begin
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL done_pulse: got done_o=1, expected 0");
        end else begin
          e = dq.pop_front();
          checkOutput("done_cycle", cyc, e.cyc);
          checkOutput("done_x", int'(x_o), dx(e.value));
          checkOutput("done_settled", int'(settled_o), 1);
        end
      end
    end
  endtask

  task automatic mainSeq();
    int a;
    int a1;
    int a2;
    int g;

    resetDut();

    // Up ramp 0 -> 16 in steps of 4
    applyStimulus(16, 4, a);
    checkOutput("busy_after_accept", int'(busy_o), 1);
    checkOutput("ready_after_accept", int'(cfg_ready_o), 0);
    pushX(4, a + 4);
    pushX(8, a + 8);
    pushX(12, a + 12);
    pushX(16, a + 16);
    pushDone(16, a + 19);
    waitDrain(40);
    checkOutput("up_settled", int'(settled_o), 1);
    checkOutput("up_ready", int'(cfg_ready_o), 1);

    // Down ramp 16 -> 5, last step clamped
    applyStimulus(5, 4, a);
    pushX(12, a + 4);
    pushX(8, a + 8);
    pushX(5, a + 12);
    pushDone(5, a + 15);
    waitDrain(40);

    // Zero step jumps straight to target
    applyStimulus(300, 0, a);
    pushX(300, a + 4);
    pushDone(300, a + 7);
    waitDrain(20);

    resetDut();

    // Abort coincident with the third tick freezes x at 20
    applyStimulus(100, 10, a);
    pushX(10, a + 4);
    pushX(20, a + 8);
    g = 0;
    while (cyc != a + 11 && g < 50) begin
      @(negedge clk);
      g++;
    end
    abort_i = 1'b1;
    @(posedge clk);
    #1 abort_i = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("abort_x", int'(x_o), dx(20));
    checkOutput("abort_busy", int'(busy_o), 0);
    checkOutput("abort_ready", int'(cfg_ready_o), 1);
    checkOutput("abort_settled", int'(settled_o), 0);
    waitDrain(4);

    // A request held during a ramp is taken on the first IDLE cycle
    applyStimulus(28, 8, a1);
    pushX(28, a1 + 4);
    pushDone(28, a1 + 7);
    applyStimulus(40, 0, a2);
    checkOutput("held_accept_edge", a2, a1 + 8);
    pushX(40, a2 + 4);
    pushDone(40, a2 + 7);
    waitDrain(30);

    // Target equal to current word still costs one tick plus settle
    applyStimulus(40, 3, a);
    pushDone(40, a + 7);
    waitDrain(20);
    checkOutput("equal_settled", int'(settled_o), 1);
    checkOutput("equal_x", int'(x_o), dx(40));
  endtask

  initial begin
    rst         = 1'b1;
    cfg_valid_i = 1'b0;
    cfg_word_i  = '0;
    cfg_step_i  = '0;
    abort_i     = 1'b0;
    checks      = 0;
    errors      = 0;
    prev_x      = -1;
    fork
      begin
        forever begin
          @(negedge clk);
          monitorStep();
        end
      end
      begin
        mainSeq();
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish within 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
